div_unit: RTL and testbench



---
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} with signed/unsigned modes, divide-by-zero flag and flush.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o,
  output logic [1:0]         dbg_state
);

  // Handshake: an op is accepted on a rising edge in IDLE with start_i=1 and annul_i=0;
  // ready_o then stays high in END while start_i is held, and start_i=0 returns to IDLE.
  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quo_q, rem_q, dsr_q;
  logic               neg_quo_q, neg_rem_q;

  logic               accept;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     shifted, trial;
  logic               take;
  logic [WIDTH-1:0]   rem_next, quo_next, quo_fix, rem_fix;

  logic [2*WIDTH-1:0] result_d;
  logic               ready_d, busy_d, dbz_d;

  assign accept  = (state_q == S_IDLE) && start_i && !annul_i;
  assign op1_neg = signed_div_i && opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i && opdata2_i[WIDTH-1];
  assign abs1    = op1_neg ? -opdata1_i : opdata1_i;
  assign abs2    = op2_neg ? -opdata2_i : opdata2_i;

  // The quotient register starts out holding the dividend and shifts its bits into
  // the partial remainder while quotient bits fill in from the bottom.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr_q};
  assign take     = !trial[WIDTH];
  assign rem_next = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], take};

  assign quo_fix  = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dsr_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      busy_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_o      <= result_d;
      ready_o       <= ready_d;
      busy_o        <= busy_d;
      div_by_zero_o <= dbz_d;
      if (accept) begin
        quo_q     <= abs1;
        dsr_q     <= abs2;
        rem_q     <= '0;
        cnt_q     <= '0;
        neg_quo_q <= op1_neg ^ op2_neg;
        neg_rem_q <= op1_neg;
      end else if (state_q == S_ON && cnt_q != LAST) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = (opdata2_i == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: state_d = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)            state_d = S_IDLE;
        else if (cnt_q == LAST) state_d = S_END;
      end
      S_END:     state_d = (annul_i || !start_i) ? S_IDLE : S_END;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_d = result_o;
    ready_d  = ready_o;
    dbz_d    = div_by_zero_o;
    busy_d   = (state_d == S_DIVZERO) || (state_d == S_ON);
    if (state_d == S_IDLE) begin
      result_d = '0;
      ready_d  = 1'b0;
      dbz_d    = 1'b0;
    end else if (state_q == S_DIVZERO && state_d == S_END) begin
      result_d = '0;
      ready_d  = 1'b1;
      dbz_d    = 1'b1;
    end else if (state_q == S_ON && state_d == S_END) begin
      result_d = {rem_fix, quo_fix};
      ready_d  = 1'b1;
      dbz_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: 32-bit and 8-bit instances checked against an
// arithmetic reference model (truncating division, remainder follows the dividend).
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, annul, sgn;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, busy, dbz;
  logic [1:0]  dbg;

  logic        start8, annul8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        ready8, busy8, dbz8;
  logic [1:0]  dbg8;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
    .opdata1_i(a), .opdata2_i(b), .result_o(result), .ready_o(ready),
    .busy_o(busy), .div_by_zero_o(dbz), .dbg_state(dbg)
  );

  div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .signed_div_i(sgn8),
    .opdata1_i(a8), .opdata2_i(b8), .result_o(result8), .ready_o(ready8),
    .busy_o(busy8), .div_by_zero_o(dbz8), .dbg_state(dbg8)
  );

  // Reference: sign-extend (signed mode), divide with truncation toward zero, wrap to w bits.
  function automatic logic [63:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [31:0] mask;
    longint sx, sy, q, r;
    logic [31:0] qm, rm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if ((y & mask) == 32'd0) return 64'd0;
    sx = longint'(x & mask);
    sy = longint'(y & mask);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    q  = sx / sy;
    r  = sx % sy;
    qm = q[31:0] & mask;
    rm = r[31:0] & mask;
    return (64'(rm) << w) | 64'(qm);
  endfunction

  task automatic drive32(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [63:0] res, output logic dz, output int lat, output int bsy);
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    lat = 0; bsy = 0;
    forever begin
      @(posedge clk); lat++; #1;
      a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
      if (ready) break;
      if (busy) bsy++;
      if (lat >= 100) break;
    end
    res = result; dz = dbz;
  endtask

  task automatic release32(output logic r_ready, output logic [63:0] r_res, output logic r_dz);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    r_ready = ready; r_res = result; r_dz = dbz;
  endtask

  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        output logic [15:0] res, output logic dz, output int lat);
    @(negedge clk);
    a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
    lat = 0;
    forever begin
      @(posedge clk); lat++; #1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (ready8) break;
      if (lat >= 100) break;
    end
    res = result8; dz = dbz8;
    @(negedge clk); start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start8 = 1'b0; annul8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({result, ready, busy, dbz, dbg} !== 69'd0) begin
      errors++;
      $display("FAIL reset32: got res=%h rdy=%b busy=%b dz=%b st=%0d, want all 0",
               result, ready, busy, dbz, dbg);
    end
    checks++;
    if ({result8, ready8, busy8, dbz8, dbg8} !== 21'd0) begin
      errors++;
      $display("FAIL reset8: got res=%h rdy=%b busy=%b dz=%b st=%0d, want all 0",
               result8, ready8, busy8, dbz8, dbg8);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] xt[5] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] yt[5] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
    logic        st[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] et[5] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                           {32'h0000_0001, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                           {32'h0, 32'hFFFF_FFFF}};
    logic [63:0] res, rres, exp;
    logic dz, rrdy, rdz;
    int lat, bsy;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(et[i]);
      drive32(xt[i], yt[i], st[i], res, dz, lat, bsy);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || dz !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] result: got %h dz=%b, want %h dz=0", i, res, dz, exp);
      end
      checks++;
      if (lat != 34 || bsy != 33) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d edges busy=%0d, want 34 busy=33", i, lat, bsy);
      end
      release32(rrdy, rres, rdz);
      checks++;
      if (rrdy !== 1'b0 || rres !== 64'd0 || rdz !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] release: got rdy=%b res=%h dz=%b, want 0", i, rrdy, rres, rdz);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res, rres;
    logic dz, rrdy, rdz;
    int lat, bsy;
    for (int i = 0; i < 2; i++) begin
      drive32((i == 0) ? 32'd5 : 32'hFFFF_FFFD, 32'd0, 1'(i), res, dz, lat, bsy);
      checks++;
      if (res !== 64'd0 || dz !== 1'b1 || lat != 2 || bsy != 1) begin
        errors++;
        $display("FAIL divzero[%0d]: got res=%h dz=%b lat=%0d busy=%0d, want 0 1 2 1",
                 i, res, dz, lat, bsy);
      end
      release32(rrdy, rres, rdz);
      checks++;
      if (rrdy !== 1'b0 || rdz !== 1'b0) begin
        errors++;
        $display("FAIL divzero[%0d] release: got rdy=%b dz=%b, want 0 0", i, rrdy, rdz);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic s, dz, rrdy, rdz;
    logic [63:0] res, rres, exp;
    int lat, bsy;
    for (int i = 0; i < 30; i++) begin
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      exp_q.push_back(model(32, x, y, s));
      drive32(x, y, s, res, dz, lat, bsy);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || dz !== (y == 32'd0) || lat != ((y == 32'd0) ? 2 : 34)) begin
        errors++;
        $display("FAIL random[%0d] %h/%h s=%b: got %h dz=%b lat=%0d, want %h dz=%b lat=%0d",
                 i, x, y, s, res, dz, lat, exp, (y == 32'd0), (y == 32'd0) ? 2 : 34);
      end
      release32(rrdy, rres, rdz);
    end
  endtask

  task automatic test_annul();
    logic [63:0] res, rres;
    logic dz, rrdy, rdz, seen;
    int lat, bsy;
    // Annul in the middle of the iteration phase, start held through the annul edge.
    @(negedge clk); a = 32'd100; b = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int e = 1; e < 10; e++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (seen || ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL annul_on: got early=%b rdy=%b busy=%b res=%h dz=%b, want all 0",
               seen, ready, busy, result, dbz);
    end
    @(negedge clk); annul = 1'b0; start = 1'b0;
    drive32(32'd9, 32'd3, 1'b0, res, dz, lat, bsy);
    checks++;
    if (res !== {32'd0, 32'd3} || lat != 34) begin
      errors++;
      $display("FAIL annul_restart: got %h lat=%0d, want %h lat=34", res, lat, {32'd0, 32'd3});
    end
    // Annul in END while start is still high.
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL annul_end: got rdy=%b res=%h, want 0 0", ready, result);
    end
    @(negedge clk); annul = 1'b0; start = 1'b0;
    // Annul in DIVZERO.
    @(negedge clk); a = 32'd4; b = 32'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || dbz !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL annul_divzero: got rdy=%b dz=%b busy=%b, want 0 0 0", ready, dbz, busy);
    end
    @(negedge clk); annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    logic [63:0] res, rres, exp;
    logic dz, rrdy, rdz;
    int lat, bsy;
    exp_q.push_back({32'd0, 32'd100});
    drive32(32'd1000, 32'd10, 1'b0, res, dz, lat, bsy);
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || result !== exp || busy !== 1'b0) begin
        errors++;
        $display("FAIL hold_end[%0d]: got rdy=%b res=%h busy=%b, want 1 %h 0",
                 i, ready, result, busy, exp);
      end
    end
    release32(rrdy, rres, rdz);
    x = $urandom; y = $urandom_range(1, 1000);
    exp_q.push_back(model(32, x, y, 1'b1));
    drive32(x, y, 1'b1, res, dz, lat, bsy);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp || lat != 34) begin
      errors++;
      $display("FAIL back_to_back: got %h lat=%0d, want %h lat=34", res, lat, exp);
    end
    release32(rrdy, rres, rdz);
  endtask

  task automatic test_width8();
    logic [7:0] x, y;
    logic s, dz;
    logic [15:0] res, exp;
    logic [63:0] m;
    int lat;
    drive8(8'd200, 8'd3, 1'b0, res, dz, lat);
    checks++;
    if (res !== {8'd2, 8'd66} || dz !== 1'b0 || lat != 10) begin
      errors++;
      $display("FAIL w8_200_3: got %h dz=%b lat=%0d, want 0242 dz=0 lat=10", res, dz, lat);
    end
    for (int i = 0; i < 12; i++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      s = 1'($urandom_range(0, 1));
      m = model(8, {24'd0, x}, {24'd0, y}, s);
      exp_q.push_back(m);
      drive8(x, y, s, res, dz, lat);
      m = exp_q.pop_front();
      exp = m[15:0];
      checks++;
      if (res !== exp || dz !== (y == 8'd0) || lat != ((y == 8'd0) ? 2 : 10)) begin
        errors++;
        $display("FAIL w8_random[%0d] %h/%h s=%b: got %h dz=%b lat=%0d, want %h", i, x, y, s,
                 res, dz, lat, exp);
      end
    end
    // Synchronous reset in the middle of an operation.
    @(negedge clk); a8 = 8'd200; b8 = 8'd3; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_busy_before_rst: got busy=%b, want 1", busy8);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({result8, ready8, busy8, dbz8, dbg8} !== 21'd0) begin
      errors++;
      $display("FAIL w8_rst_mid_op: got res=%h rdy=%b busy=%b dz=%b st=%0d, want all 0",
               result8, ready8, busy8, dbz8, dbg8);
    end
    @(negedge clk); rst = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_annul();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
